window_fetch_ctrl: RTL and testbench
====================================

# window_fetch_ctrl

Sequencer for the convolution window shift register. The block scans a stored IMG_H x IMG_W byte image with a K x K kernel at stride 1. For each output position it issues the K*K byte reads in row-major tap order to a single-port memory with one-cycle read latency. It drives the window register's byte-enable and select so the read data shifts in, then offers the full window to the MAC stage with a valid/ready handshake.

## Interface
- BYTE_WIDTH, 8: byte width of the image data. Informational only; no port uses it.
- IMG_W, 5: image width in bytes. Must be at least K.
- IMG_H, 5: image height in rows. Must be at least K.
- K, 3: kernel side length. The window holds K*K bytes.
- ADDR_WIDTH, 8: memory address width. Must be at least clog2(IMG_W*IMG_H); elaboration fails otherwise.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  begin a full-image scan. Sampled only in IDLE.
- i_abort  in  1  return to IDLE on the next edge from any state. No o_done is produced.
- o_rd_en  out  1  memory read strobe.
- o_rd_addr  out  ADDR_WIDTH  memory read address, valid while o_rd_en=1.
- o_enb_byt  out  1  window byte enable. It is o_rd_en delayed one cycle, so it aligns with memory data.
- o_equal_addr  out  1  window select. High in FETCH and WAIT, low otherwise.
- o_win_valid  out  1  the window register holds a complete K*K window.
- i_win_ready  in  1  consumer accepts the window.
- o_row  out  ADDR_WIDTH  row of the current window's top-left tap.
- o_col  out  ADDR_WIDTH  column of the current window's top-left tap.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse after the last window is accepted.

## Operation
- FSM states: IDLE, FETCH, WAIT, PRESENT, DONE.
- IDLE
  - If i_start=1: clear row, col, kr and kc, then go to FETCH.
  - If i_start=0: stay in IDLE.
- FETCH
  - o_rd_en=1 every cycle.
  - o_rd_addr = (row+kr)*IMG_W + (col+kc), computed incrementally with no multiplier.
  - kc counts 0..K-1, then wraps to 0 and increments kr.
  - After tap (K-1,K-1), go to WAIT.
- WAIT
  - One cycle. o_enb_byt=1 for the final byte, o_rd_en=0.
  - Then go to PRESENT.
- PRESENT
  - o_win_valid=1, held until i_win_ready=1.
  - o_row and o_col stay stable throughout.
  - On handshake, if col < IMG_W-K: col+1, then FETCH.
  - Otherwise, if row < IMG_H-K: col=0, row+1, then FETCH.
  - Otherwise go to DONE.
- DONE
  - o_done=1 for one cycle, then IDLE.
- Tap order: the first tap read ends in the window's most-significant byte and tap (K-1,K-1) in the least-significant byte.
- Ignored inputs:
  - i_start while busy.
  - i_win_ready outside PRESENT.
- i_abort
  - Has priority over every other transition.
  - Clears o_rd_en, o_win_valid and the o_enb_byt pipeline stage on the next edge.
  - Partial window contents are not cleared.

## Timing
- Reset values: state=IDLE. o_rd_en, o_enb_byt, o_equal_addr, o_win_valid, o_busy and o_done are all 0; o_rd_addr, o_row and o_col are all 0.
- All outputs are registered or decoded from the registered state; there are no combinational input-to-output paths.
- Start latency: i_start high at edge N gives o_rd_en=1 with tap 0 during cycle N+1.
- Per window: K*K FETCH cycles + 1 WAIT + at least 1 PRESENT cycle. With K=3 and i_win_ready held high, that is 11 cycles per window.
- Back-to-back: FETCH for the next window starts the cycle after the handshake edge.
- o_done rises the cycle after the last handshake.
- i_win_ready is allowed high before o_win_valid rises; acceptance happens in the first PRESENT cycle.
- Reset asserted mid-scan forces every output to its reset value asynchronously. Scanning resumes only on a new i_start.

## Test plan
- Reset and idle: assert rst during FETCH of window 3 -> all outputs 0 immediately; the block stays in IDLE with i_start=0.
- Address sequence, first window: IMG_W=IMG_H=5, K=3, start -> o_rd_addr = 0,1,2,5,6,7,10,11,12 on consecutive cycles. o_enb_byt lags o_rd_en by exactly 1 cycle. o_win_valid is first high 10 cycles after the first o_rd_en.
- Full scan with i_win_ready tied high -> 9 windows, (row,col) = (0,0)…(2,2). Window (1,2) addresses are 7,8,9,12,13,14,17,18,19. o_done pulses at 99 cycles after the first o_rd_en, then o_busy=0.
- Backpressure: hold i_win_ready=0 for 5 cycles at window (0,1) -> o_win_valid stays high and o_row/o_col stay at (0,1). No o_rd_en is issued until the handshake; the next window fetch begins at address 2.
- Abort mid-fetch at tap 4, then i_start again -> IDLE on the next edge, no o_done. The new scan restarts at address 0.
- Start while busy: pulse i_start during PRESENT -> no effect on sequence, counters or o_done timing.

Source files
------------

// File: rtl/window_fetch_ctrl_if.sv
// Handshake and memory-request bundle between the window fetch sequencer and its neighbours.
interface window_fetch_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  i_start;
  logic                  i_abort;
  logic                  o_rd_en;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic                  o_enb_byt;
  logic                  o_equal_addr;
  logic                  o_win_valid;
  logic                  i_win_ready;
  logic [ADDR_WIDTH-1:0] o_row;
  logic [ADDR_WIDTH-1:0] o_col;
  logic                  o_busy;
  logic                  o_done;

  // Sequencer side
  modport master (
    input  i_start, i_abort, i_win_ready,
    output o_rd_en, o_rd_addr, o_enb_byt, o_equal_addr, o_win_valid,
           o_row, o_col, o_busy, o_done
  );

  // Control / memory / MAC side
  modport slave (
    output i_start, i_abort, i_win_ready,
    input  o_rd_en, o_rd_addr, o_enb_byt, o_equal_addr, o_win_valid,
           o_row, o_col, o_busy, o_done
  );
endinterface

// File: rtl/window_fetch_ctrl.sv
// Scans an IMG_H x IMG_W byte image with a KxK stride-1 window, issuing the
// K*K tap reads per window and handing each complete window to the MAC stage.
module window_fetch_ctrl #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned IMG_W      = 5,
  parameter int unsigned IMG_H      = 5,
  parameter int unsigned K          = 3,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  window_fetch_ctrl_if.master bus
);

  localparam int unsigned KW       = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned ROW_STEP = IMG_W - K + 1;
  localparam int unsigned COL_LAST = IMG_W - K;
  localparam int unsigned ROW_LAST = IMG_H - K;

  // Reject parameter sets the address arithmetic cannot represent
  if (ADDR_WIDTH < $clog2(IMG_W * IMG_H)) begin : g_addr_chk
    $error("ADDR_WIDTH too narrow for IMG_W*IMG_H");
  end
  if (IMG_W < K || IMG_H < K || K < 1) begin : g_dim_chk
    $error("image must be at least K x K");
  end
  if (BYTE_WIDTH < 1) begin : g_byte_chk
    $error("BYTE_WIDTH must be non-zero");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state;
  logic [KW-1:0]         kr;
  logic [KW-1:0]         kc;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0] base;   // row*IMG_W + col, kept incrementally
  logic                  tap_last;
  logic                  kc_last;

  assign kc_last  = (kc == KW'(K - 1));
  assign tap_last = kc_last && (kr == KW'(K - 1));

  assign bus.o_row = row;
  assign bus.o_col = col;

  // Scan sequencer with registered strobes; abort overrides every transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      kr               <= '0;
      kc               <= '0;
      row              <= '0;
      col              <= '0;
      base             <= '0;
      bus.o_rd_en      <= 1'b0;
      bus.o_rd_addr    <= '0;
      bus.o_enb_byt    <= 1'b0;
      bus.o_equal_addr <= 1'b0;
      bus.o_win_valid  <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
    end else begin
      bus.o_enb_byt <= bus.o_rd_en;
      if (bus.i_abort) begin
        state            <= IDLE;
        bus.o_rd_en      <= 1'b0;
        bus.o_enb_byt    <= 1'b0;
        bus.o_equal_addr <= 1'b0;
        bus.o_win_valid  <= 1'b0;
        bus.o_busy       <= 1'b0;
        bus.o_done       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_start) begin
              row              <= '0;
              col              <= '0;
              base             <= '0;
              kr               <= '0;
              kc               <= '0;
              bus.o_rd_addr    <= '0;
              bus.o_rd_en      <= 1'b1;
              bus.o_equal_addr <= 1'b1;
              bus.o_busy       <= 1'b1;
              state            <= FETCH;
            end
          end
          FETCH: begin
            if (tap_last) begin
              bus.o_rd_en <= 1'b0;
              state       <= WAIT;
            end else if (kc_last) begin
              kc            <= '0;
              kr            <= kr + KW'(1);
              bus.o_rd_addr <= bus.o_rd_addr + ADDR_WIDTH'(ROW_STEP);
            end else begin
              kc            <= kc + KW'(1);
              bus.o_rd_addr <= bus.o_rd_addr + ADDR_WIDTH'(1);
            end
          end
          WAIT: begin
            bus.o_equal_addr <= 1'b0;
            bus.o_win_valid  <= 1'b1;
            state            <= PRESENT;
          end
          PRESENT: begin
            if (bus.i_win_ready) begin
              bus.o_win_valid <= 1'b0;
              kr              <= '0;
              kc              <= '0;
              if (col < ADDR_WIDTH'(COL_LAST)) begin
                col              <= col + ADDR_WIDTH'(1);
                base             <= base + ADDR_WIDTH'(1);
                bus.o_rd_addr    <= base + ADDR_WIDTH'(1);
                bus.o_rd_en      <= 1'b1;
                bus.o_equal_addr <= 1'b1;
                state            <= FETCH;
              end else if (row < ADDR_WIDTH'(ROW_LAST)) begin
                col              <= '0;
                row              <= row + ADDR_WIDTH'(1);
                base             <= base - col + ADDR_WIDTH'(IMG_W);
                bus.o_rd_addr    <= base - col + ADDR_WIDTH'(IMG_W);
                bus.o_rd_en      <= 1'b1;
                bus.o_equal_addr <= 1'b1;
                state            <= FETCH;
              end else begin
                bus.o_done <= 1'b1;
                state      <= DONE;
              end
            end
          end
          DONE: begin
            bus.o_done <= 1'b0;
            bus.o_busy <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Bench for window_fetch_ctrl: address scoreboard plus a per-window vector table.
module tb_window_fetch_ctrl;

  localparam int unsigned IMG_W = 5;
  localparam int unsigned IMG_H = 5;
  localparam int unsigned K     = 3;
  localparam int unsigned AW    = 8;
  localparam int unsigned NCOL  = IMG_W - K + 1;
  localparam int unsigned NWIN  = NCOL * (IMG_H - K + 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  window_fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  window_fetch_ctrl #(
    .BYTE_WIDTH(8),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .K         (K),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int stall;        // cycles i_win_ready held low while the window is offered
    bit early;        // i_win_ready raised before o_win_valid
    bit pulse_start;  // i_start pulsed at the handshake cycle
    int exp_row;
    int exp_col;
  } vec_t;

  vec_t vec[NWIN];
  int   addr_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   prev_rd_en = 1'b0;
  bit   abort_now  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected tap addresses for window (r,c), computed directly from the geometry
  task automatic push_window(input int r, input int c);
    for (int kr = 0; kr < int'(K); kr++)
      for (int kc = 0; kc < int'(K); kc++)
        addr_q.push_back((r + kr) * int'(IMG_W) + c + kc);
  endtask

  // One clock; sample just after the edge and score the read port
  task automatic step();
    bit exp_enb;
    @(posedge clk);
    #1;
    cyc++;
    exp_enb = abort_now ? 1'b0 : prev_rd_en;
    check("enb_lag", 32'(bus.o_enb_byt), 32'(exp_enb));
    prev_rd_en = bus.o_rd_en;
    if (bus.o_rd_en === 1'b1) begin
      check("rd_queue_nonempty", 32'(addr_q.size() > 0), 32'd1);
      check("equal_addr_fetch", 32'(bus.o_equal_addr), 32'd1);
      if (addr_q.size() > 0) check("rd_addr", 32'(bus.o_rd_addr), 32'(addr_q.pop_front()));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(bus.o_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(bus.o_rd_addr), 32'd0);
    check({tag, "_enb"}, 32'(bus.o_enb_byt), 32'd0);
    check({tag, "_eq"}, 32'(bus.o_equal_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.o_win_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_done"}, 32'(bus.o_done), 32'd0);
    check({tag, "_row"}, 32'(bus.o_row), 32'd0);
    check({tag, "_col"}, 32'(bus.o_col), 32'd0);
  endtask

  // Wait (bounded) for the next offered window
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.o_win_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("valid_seen", 32'(bus.o_win_valid), 32'd1);
  endtask

  // Full image scan driven from the vector table
  task automatic run_scan(input bit mods);
    int t0;
    int last_hs;
    int total_stall;
    int n;
    total_stall = 0;
    addr_q.delete();
    push_window(0, 0);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    check("start_rd_en", 32'(bus.o_rd_en), 32'd1);
    check("start_busy", 32'(bus.o_busy), 32'd1);
    t0      = cyc;
    last_hs = cyc - 1;
    for (int i = 0; i < int'(NWIN); i++) begin
      if (mods && vec[i].early) bus.i_win_ready = 1'b1;
      wait_valid(n);
      check("valid_cycle", 32'(cyc), 32'(last_hs + 11));
      check("win_row", 32'(bus.o_row), 32'(vec[i].exp_row));
      check("win_col", 32'(bus.o_col), 32'(vec[i].exp_col));
      check("eq_low_present", 32'(bus.o_equal_addr), 32'd0);
      if (mods) begin
        for (int j = 0; j < vec[i].stall; j++) begin
          step();
          total_stall++;
          check("stall_valid", 32'(bus.o_win_valid), 32'd1);
          check("stall_row", 32'(bus.o_row), 32'(vec[i].exp_row));
          check("stall_col", 32'(bus.o_col), 32'(vec[i].exp_col));
        end
        bus.i_start = vec[i].pulse_start;
      end
      bus.i_win_ready = 1'b1;
      if (i < int'(NWIN) - 1) push_window(vec[i+1].exp_row, vec[i+1].exp_col);
      last_hs = cyc;
      step();
      bus.i_win_ready = 1'b0;
      bus.i_start     = 1'b0;
      check("valid_drop", 32'(bus.o_win_valid), 32'd0);
    end
    check("done_pulse", 32'(bus.o_done), 32'd1);
    check("done_cycle", 32'(cyc - t0), 32'(int'(NWIN) * (int'(K * K) + 2) + total_stall));
    check("scan_reads_consumed", 32'(addr_q.size()), 32'd0);
    step();
    check("done_clear", 32'(bus.o_done), 32'd0);
    check("busy_after_done", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int  n;
    bit  saw_done;

    for (int i = 0; i < int'(NWIN); i++) begin
      vec[i].stall       = 0;
      vec[i].early       = 1'b0;
      vec[i].pulse_start = 1'b0;
      vec[i].exp_row     = i / int'(NCOL);
      vec[i].exp_col     = i % int'(NCOL);
    end
    vec[1].stall       = 5;
    vec[3].early       = 1'b1;
    vec[4].pulse_start = 1'b1;
    vec[6].stall       = 2;
    vec[6].pulse_start = 1'b1;

    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_win_ready = 1'b0;

    // Reset state and idle hold
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) step();
    check_all_zero("idle");

    // Abort at tap 4, then restart from address 0
    addr_q.delete();
    push_window(0, 0);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    repeat (4) step();
    check("abort_tap4_addr", 32'(bus.o_rd_addr), 32'd6);
    bus.i_abort = 1'b1;
    abort_now   = 1'b1;
    step();
    bus.i_abort = 1'b0;
    abort_now   = 1'b0;
    check("abort_rd_en", 32'(bus.o_rd_en), 32'd0);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    check("abort_eq", 32'(bus.o_equal_addr), 32'd0);
    check("abort_valid", 32'(bus.o_win_valid), 32'd0);
    addr_q.delete();
    saw_done = 1'b0;
    repeat (6) begin
      step();
      saw_done |= bus.o_done;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    // Plain full scan (also the post-abort restart), then a scan with stalls/early ready/start pulses
    run_scan(1'b0);
    repeat (2) step();
    run_scan(1'b1);

    // Reset asserted during the fetch of the third window
    addr_q.delete();
    push_window(0, 0);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wait_valid(n);
      push_window(vec[w+1].exp_row, vec[w+1].exp_col);
      bus.i_win_ready = 1'b1;
      step();
      bus.i_win_ready = 1'b0;
    end
    step();
    step();
    check("pre_reset_fetching", 32'(bus.o_rd_en), 32'd1);
    #2;
    rst        = 1'b1;
    prev_rd_en = 1'b0;
    #1;
    check_all_zero("async_reset");
    addr_q.delete();
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    check_all_zero("post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
